// File: rtl/ext_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_pkg
// Description : Shared widths, FSM state type and address range helper for
//               the external memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  // An address is in range when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int depth_log2);
    return (addr >> depth_log2) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_responder_if
// Description : Read/write request bus between the data loader (master) and
//               the external memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ext_mem_responder_if;

  logic                            rvalid;
  logic [ext_mem_pkg::ADDR_W-1:0]  raddr;
  logic                            rready;
  logic [ext_mem_pkg::DATA_W-1:0]  rdata;
  logic                            wvalid;
  logic [ext_mem_pkg::ADDR_W-1:0]  waddr;
  logic [ext_mem_pkg::DATA_W-1:0]  wdata;
  logic                            wready;
  logic                            err;
  logic [31:0]                     rd_count;
  logic [31:0]                     wr_count;

  modport master (
    output rvalid, raddr, wvalid, waddr, wdata,
    input  rready, rdata, wready, err, rd_count, wr_count
  );

  modport slave (
    input  rvalid, raddr, wvalid, waddr, wdata,
    output rready, rdata, wready, err, rd_count, wr_count
  );

endinterface
`default_nettype wire

// File: rtl/ext_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_array
// Description : Single-port word RAM, synchronous write and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
import ext_mem_pkg::*;

module ext_mem_array #(
  parameter int DEPTH_LOG2 = 16
) (
  input  wire logic                  clk,
  input  wire logic                  we,
  input  wire logic                  re,
  input  wire logic [DEPTH_LOG2-1:0] addr,
  input  wire logic [DATA_W-1:0]     wdata,
  output      logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ext_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_responder
// Description : On-chip stand-in for external DRAM; serves one read or write
//               at a time, writes first, with RD_LAT-cycle read latency.
//               Define EXTMEM_STATS_EN to enable the rd/wr pulse counters.
// Revision    : 1.0 - initial release
// ============================================================================
import ext_mem_pkg::*;

module ext_mem_responder #(
  parameter int DEPTH_LOG2 = 16,
  parameter int RD_LAT     = 2
) (
  input wire logic           clk,
  input wire logic           rst,
  ext_mem_responder_if.slave bus
);

  localparam logic [LAT_W-1:0] c_lat_init = LAT_W'(RD_LAT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LAT_W-1:0]        r_lat;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_oor;
  logic                    r_err;
  logic [DATA_W-1:0]       r_rdata_hold;

  logic                    w_cap_wr;
  logic                    w_cap_rd;
  logic                    w_mem_we;
  logic                    w_mem_re;
  logic [DEPTH_LOG2-1:0]   w_mem_addr;
  logic [DATA_W-1:0]       w_mem_rdata;
  logic [DATA_W-1:0]       w_resp_data;
  logic                    w_wr_in_range;
  logic                    w_rd_in_range;

  assign w_wr_in_range = addr_in_range(bus.waddr, DEPTH_LOG2);
  assign w_rd_in_range = addr_in_range(bus.raddr, DEPTH_LOG2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lat        <= '0;
      r_addr       <= '0;
      r_oor        <= 1'b0;
      r_err        <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap_rd) begin
        r_addr <= bus.raddr;
        r_oor  <= !w_rd_in_range;
        r_lat  <= c_lat_init;
      end else if (r_state == RD_WAIT) begin
        r_lat <= r_lat - LAT_W'(1);
      end
      if ((w_cap_wr && !w_wr_in_range) || (w_cap_rd && !w_rd_in_range)) begin
        r_err <= 1'b1;
      end
      if (r_state == RD_RESP) begin
        r_rdata_hold <= w_resp_data;
      end
    end
  end

  // The array is written in the capture cycle of a write and read either in
  // the capture cycle (RD_LAT=1) or in the last RD_WAIT cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_wr    = 1'b0;
    w_cap_rd    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = r_addr[DEPTH_LOG2-1:0];
    case (r_state)
      IDLE: begin
        if (bus.wvalid) begin
          w_cap_wr    = 1'b1;
          w_mem_we    = w_wr_in_range && !rst;
          w_mem_addr  = bus.waddr[DEPTH_LOG2-1:0];
          w_state_nxt = WR_RESP;
        end else if (bus.rvalid) begin
          w_cap_rd = 1'b1;
          if (RD_LAT == 1) begin
            w_mem_re    = w_rd_in_range && !rst;
            w_mem_addr  = bus.raddr[DEPTH_LOG2-1:0];
            w_state_nxt = RD_RESP;
          end else begin
            w_state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_lat == LAT_W'(1)) begin
          w_mem_re    = !r_oor && !rst;
          w_state_nxt = RD_RESP;
        end
      end
      RD_RESP: w_state_nxt = IDLE;
      WR_RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  ext_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .re    (w_mem_re),
    .addr  (w_mem_addr),
    .wdata (bus.wdata),
    .rdata (w_mem_rdata)
  );

  assign w_resp_data = r_oor ? '0 : w_mem_rdata;
  assign bus.rready  = (r_state == RD_RESP);
  assign bus.wready  = (r_state == WR_RESP);
  assign bus.rdata   = (r_state == RD_RESP) ? w_resp_data : r_rdata_hold;
  assign bus.err     = r_err;

`ifdef EXTMEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == RD_RESP) r_rd_count <= r_rd_count + 32'd1;
      if (r_state == WR_RESP) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;
`else
  assign bus.rd_count = '0;
  assign bus.wr_count = '0;
`endif

endmodule
`default_nettype wire
